// File: rtl/alu_operand_stage_if.sv
// Decoded-op handshake between the decoder (master) and alu_operand_stage (slave).
interface alu_operand_stage_if #(
  parameter int AW   = 4,
  parameter int IMMW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_func;
  logic [AW-1:0]   in_rs;
  logic [AW-1:0]   in_rt;
  logic [AW-1:0]   in_rd;
  logic [IMMW-1:0] in_imm;
  logic            in_use_imm;
  logic            in_wb;

  modport master (
    output in_valid, in_func, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_wb,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_func, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_wb,
    output in_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback pipeline around an external combinational ALU, with register file.
// Build option: define ALU_FWD_EN to forward pending results instead of stalling on RAW hazards.
module alu_operand_stage #(
  parameter int N    = 32,
  parameter int AW   = 4,
  parameter int IMMW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_stage_if.slave   op_if,
  output logic [N-1:0]         alu_a_o,
  output logic [N-1:0]         alu_b_o,
  output logic [3:0]           alu_func_o,
  input  logic [N-1:0]         alu_res_i,
  output logic                 res_valid_o,
  output logic [AW-1:0]        res_rd_o,
  output logic [N-1:0]         res_data_o,
  input  logic [AW-1:0]        dbg_addr_i,
  output logic [N-1:0]         dbg_data_o
);

  localparam int NREG = 2**AW;

  logic [N-1:0]  rf_q [NREG];

  logic          op_v_q, op_v_d;
  logic          op_wb_q, op_wb_d;
  logic [AW-1:0] op_rd_q, op_rd_d;
  logic [N-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_func_q, alu_func_d;

  logic          wb_v_q, wb_v_d;
  logic          wb_wb_q, wb_wb_d;
  logic [AW-1:0] res_rd_q, res_rd_d;
  logic [N-1:0]  res_data_q, res_data_d;

  logic [N-1:0]  rs_rf, rt_rf, imm_ext;
  logic [N-1:0]  a_val, b_val;
  logic          rs_hit_op, rs_hit_wb, rt_hit_op, rt_hit_wb;
  logic          op_pend, wb_pend;
  logic          in_ready;
  logic          accept;
  logic          rf_we;

  assign imm_ext = {{(N-IMMW){op_if.in_imm[IMMW-1]}}, op_if.in_imm};
  assign op_pend = op_v_q && op_wb_q && (op_rd_q != '0);
  assign wb_pend = wb_v_q && wb_wb_q && (res_rd_q != '0);
  assign rf_we   = wb_pend;

  // Register 0 is hardwired to zero on every read port.
  always_comb begin
    rs_rf      = (op_if.in_rs == '0) ? '0 : rf_q[op_if.in_rs];
    rt_rf      = (op_if.in_rt == '0) ? '0 : rf_q[op_if.in_rt];
    dbg_data_o = (dbg_addr_i == '0)  ? '0 : rf_q[dbg_addr_i];
  end

  always_comb begin
    rs_hit_op = op_pend && (op_rd_q == op_if.in_rs);
    rs_hit_wb = wb_pend && (res_rd_q == op_if.in_rs);
    rt_hit_op = !op_if.in_use_imm && op_pend && (op_rd_q == op_if.in_rt);
    rt_hit_wb = !op_if.in_use_imm && wb_pend && (res_rd_q == op_if.in_rt);
`ifdef ALU_FWD_EN
    // The OP stage holds the youngest write, so it wins over WB.
    a_val = rs_hit_op ? alu_res_i : (rs_hit_wb ? res_data_q : rs_rf);
    if (op_if.in_use_imm) b_val = imm_ext;
    else                  b_val = rt_hit_op ? alu_res_i : (rt_hit_wb ? res_data_q : rt_rf);
    in_ready = !rst;
`else
    a_val    = rs_rf;
    b_val    = op_if.in_use_imm ? imm_ext : rt_rf;
    in_ready = !rst && !(rs_hit_op || rs_hit_wb || rt_hit_op || rt_hit_wb);
`endif
  end

  assign op_if.in_ready = in_ready;
  assign accept         = op_if.in_valid && in_ready;

  always_comb begin
    op_v_d     = accept;
    op_wb_d    = op_wb_q;
    op_rd_d    = op_rd_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    if (accept) begin
      op_wb_d    = op_if.in_wb;
      op_rd_d    = op_if.in_rd;
      alu_a_d    = a_val;
      alu_b_d    = b_val;
      alu_func_d = op_if.in_func;
    end
    wb_v_d     = op_v_q;
    wb_wb_d    = wb_wb_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    if (op_v_q) begin
      wb_wb_d    = op_wb_q;
      res_rd_d   = op_rd_q;
      res_data_d = alu_res_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_v_q     <= 1'b0;
      op_wb_q    <= 1'b0;
      op_rd_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      wb_v_q     <= 1'b0;
      wb_wb_q    <= 1'b0;
      res_rd_q   <= '0;
      res_data_q <= '0;
    end else begin
      op_v_q     <= op_v_d;
      op_wb_q    <= op_wb_d;
      op_rd_q    <= op_rd_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      wb_v_q     <= wb_v_d;
      wb_wb_q    <= wb_wb_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[res_rd_q] <= res_data_q;
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_func_o  = alu_func_q;
  assign res_valid_o = wb_v_q;
  assign res_rd_o    = res_rd_q;
  assign res_data_o  = res_data_q;

endmodule
